// File: rtl/montgomery_mul_pkg.sv
// Shared constants and types for the radix-2 Montgomery multiplier and its
// exponentiation controller.
package montgomery_mul_pkg;

  localparam int N       = 1024;
  localparam int ADDER_W = N + 3;
  localparam int ITER    = 1024;
  localparam int CNT_W   = 10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADD_B,
    S_WAIT_B,
    S_ADD_M,
    S_WAIT_M,
    S_SUB,
    S_WAIT_SUB,
    S_FIN
  } state_e;

  typedef enum logic [1:0] {
    OP_ZERO,
    OP_B,
    OP_M
  } op_sel_e;

  function automatic logic [ADDER_W-1:0] zext(input logic [N-1:0] v);
    return {{(ADDER_W - N){1'b0}}, v};
  endfunction

endpackage

// File: rtl/montgomery_mul_if.sv
// Request/response bundle between the exponentiation controller (master)
// and the Montgomery multiplier (slave).
interface montgomery_mul_if;
  import montgomery_mul_pkg::*;

  logic         start;
  logic [N-1:0] in_a;
  logic [N-1:0] in_b;
  logic [N-1:0] in_m;
  logic [N-1:0] result;
  logic         done;

  modport master (output start, in_a, in_b, in_m, input result, done);
  modport slave  (input start, in_a, in_b, in_m, output result, done);
endinterface

// File: rtl/montgomery_mul_mpadder.sv
// Registered 1027-bit adder/subtractor; the sum (with carry/borrow in the
// top bit) is valid, with done high, one cycle after start.
module mpadder
  import montgomery_mul_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               subtract_i,
  input  logic [ADDER_W-1:0] in_a_i,
  input  logic [ADDER_W-1:0] in_b_i,
  output logic [ADDER_W:0]   result_o,
  output logic               done_o
);

  logic [ADDER_W:0] sum_d, sum_q;
  logic             done_q;

  // Two's-complement subtract in ADDER_W+1 bits: the top bit is the borrow.
  always_comb begin
    sum_d = {1'b0, in_a_i}
          + (subtract_i ? ~{1'b0, in_b_i} : {1'b0, in_b_i})
          + {{ADDER_W{1'b0}}, subtract_i};
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= start_i;
      if (start_i) sum_q <= sum_d;
    end
  end

  assign result_o = sum_q;
  assign done_o   = done_q;

endmodule

// File: rtl/montgomery_mul.sv
// Constant-time radix-2 Montgomery multiplier: result = A*B*2^-1024 mod M,
// with every add/subtract sequenced through a single registered mpadder.
module montgomery_mul
  import montgomery_mul_pkg::*;
(
  input logic              clk,
  input logic              rst,
  montgomery_mul_if.slave  bus
);

  state_e             state_q, state_d;
  logic [N-1:0]       a_q, a_d, b_q, b_d, m_q, m_d;
  logic [N-1:0]       result_q, result_d;
  logic [ADDER_W-1:0] c_q, c_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               done_q, done_d;

  op_sel_e            op_sel;
  logic               add_start, add_sub, add_done;
  logic [ADDER_W-1:0] add_b;
  logic [ADDER_W:0]   add_sum;

  // A zero operand is substituted rather than skipping the add, so timing and
  // adder activity never depend on operand bits.
  always_comb begin
    unique case (op_sel)
      OP_B:    add_b = zext(b_q);
      OP_M:    add_b = zext(m_q);
      default: add_b = '0;
    endcase
  end

  mpadder u_adder (
    .clk        (clk),
    .rst        (rst),
    .start_i    (add_start),
    .subtract_i (add_sub),
    .in_a_i     (c_q),
    .in_b_i     (add_b),
    .result_o   (add_sum),
    .done_o     (add_done)
  );

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    m_d       = m_q;
    c_d       = c_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    done_d    = 1'b0;
    op_sel    = OP_ZERO;
    add_start = 1'b0;
    add_sub   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_d     = bus.in_a;
          b_d     = bus.in_b;
          m_d     = bus.in_m;
          c_d     = '0;
          cnt_d   = '0;
          state_d = S_ADD_B;
        end
      end
      S_ADD_B: begin
        op_sel    = a_q[0] ? OP_B : OP_ZERO;
        add_start = 1'b1;
        state_d   = S_WAIT_B;
      end
      S_WAIT_B: begin
        op_sel = a_q[0] ? OP_B : OP_ZERO;
        if (add_done) begin
          c_d     = add_sum[ADDER_W-1:0];
          state_d = S_ADD_M;
        end
      end
      S_ADD_M: begin
        op_sel    = c_q[0] ? OP_M : OP_ZERO;
        add_start = 1'b1;
        state_d   = S_WAIT_M;
      end
      S_WAIT_M: begin
        op_sel = c_q[0] ? OP_M : OP_ZERO;
        if (add_done) begin
          c_d     = add_sum[ADDER_W:1];
          a_d     = a_q >> 1;
          cnt_d   = cnt_q + 1'b1;
          state_d = (cnt_q == CNT_W'(ITER - 1)) ? S_SUB : S_ADD_B;
        end
      end
      S_SUB: begin
        op_sel    = OP_M;
        add_sub   = 1'b1;
        add_start = 1'b1;
        state_d   = S_WAIT_SUB;
      end
      S_WAIT_SUB: begin
        op_sel  = OP_M;
        add_sub = 1'b1;
        if (add_done) begin
          // Borrow out means C < M, so C is already fully reduced.
          result_d = add_sum[ADDER_W] ? c_q[N-1:0] : add_sum[N-1:0];
          done_d   = 1'b1;
          state_d  = S_FIN;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      m_q      <= '0;
      c_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      m_q      <= m_d;
      c_q      <= c_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign bus.result = result_q;
  assign bus.done   = done_q;

endmodule
